// File: rtl/ex_loader_pkg.sv
// Shared opcodes, header field positions and FSM states for the ex-mem loader.
package ex_loader_pkg;

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_RUN  = 2'b01,
        OP_DUMP = 2'b10,
        OP_RST  = 2'b11
    } opcode_e;

    localparam int OP_HI    = 31;
    localparam int OP_LO    = 30;
    localparam int LD_N_HI  = 17;
    localparam int LD_N_LO  = 9;
    localparam int LD_A_HI  = 8;
    localparam int LD_A_LO  = 0;
    localparam int RUN_C_HI = 23;
    localparam int RUN_C_LO = 0;
    localparam int DMP_S_HI = 4;
    localparam int DMP_S_LO = 0;
    localparam int DMP_K_HI = 9;
    localparam int DMP_K_LO = 5;

    localparam int RST_PULSE_CYCLES = 2;

    typedef enum logic [3:0] {
        S_IDLE,
        S_COLLECT,
        S_WRITE,
        S_RUN,
        S_SEL,
        S_SAMPLE,
        S_PUSH,
        S_RST1,
        S_RST2
    } state_e;

endpackage

// File: rtl/ex_mem_loader_if.sv
// Host link: command stream into the loader and dump stream back out.
interface ex_mem_loader_if #(
    parameter int DATA_W = 32
);
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic              m_last;

    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data, m_last
    );

    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data, m_last
    );
endinterface

// File: rtl/ex_mem_loader.sv
// Host-side driver for the riscv core: loads ex-mem word pairs, runs the core
// for a bounded cycle count, and streams debug registers back to the host.
module ex_mem_loader
    import ex_loader_pkg::*;
#(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    ex_mem_loader_if.slave    host,
    output logic              busy,
    output logic              core_reset,
    output logic              enable_load_ex_mem,
    output logic              enable_halt,
    output logic [ADDR_W-1:0] InstExMemAddress,
    output logic [DATA_W-1:0] InstExMemData1,
    output logic [DATA_W-1:0] InstExMemData2,
    output logic [ADDR_W-1:0] DataExMemAddress,
    output logic [DATA_W-1:0] DataExMemData1,
    output logic [DATA_W-1:0] DataExMemData2,
    output logic [4:0]        DebugSel,
    input  logic [DATA_W-1:0] DebugOutput
);

    state_e            state_q, state_d;
    logic [1:0]        word_idx_q, word_idx_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [8:0]        beats_q, beats_d;
    logic [23:0]       run_cnt_q, run_cnt_d;
    logic [4:0]        dump_cnt_q, dump_cnt_d;

    logic              core_reset_d, halt_d, wr_en_d, m_valid_d, m_last_d;
    logic [ADDR_W-1:0] wr_addr_d;
    logic [DATA_W-1:0] inst1_d, inst2_d, data1_d, data2_d, m_data_d;
    logic [4:0]        sel_d;

    logic              s_fire, m_fire;
    opcode_e           op;
    logic [8:0]        hdr_n, hdr_a;
    logic [23:0]       hdr_c;
    logic [4:0]        hdr_s, hdr_k;

    assign s_fire = host.s_valid && host.s_ready;
    assign m_fire = host.m_valid && host.m_ready;
    assign op     = opcode_e'(host.s_data[OP_HI:OP_LO]);
    assign hdr_n  = host.s_data[LD_N_HI:LD_N_LO];
    assign hdr_a  = host.s_data[LD_A_HI:LD_A_LO];
    assign hdr_c  = host.s_data[RUN_C_HI:RUN_C_LO];
    assign hdr_s  = host.s_data[DMP_S_HI:DMP_S_LO];
    assign hdr_k  = host.s_data[DMP_K_HI:DMP_K_LO];

    always_comb begin
        // NOTE: every signal gets a hold default first so no path can infer a latch.
        state_d      = state_q;
        word_idx_d   = word_idx_q;
        addr_d       = addr_q;
        beats_d      = beats_q;
        run_cnt_d    = run_cnt_q;
        dump_cnt_d   = dump_cnt_q;
        core_reset_d = core_reset;
        halt_d       = enable_halt;
        wr_en_d      = 1'b0;
        wr_addr_d    = InstExMemAddress;
        inst1_d      = InstExMemData1;
        inst2_d      = InstExMemData2;
        data1_d      = DataExMemData1;
        data2_d      = DataExMemData2;
        m_data_d     = host.m_data;
        m_valid_d    = host.m_valid;
        m_last_d     = host.m_last;
        sel_d        = DebugSel;

        unique case (state_q)
            S_IDLE: begin
                if (s_fire) begin
                    unique case (op)
                        OP_LOAD: begin
                            if (hdr_n != '0) begin
                                state_d      = S_COLLECT;
                                addr_d       = ADDR_W'(hdr_a);
                                beats_d      = hdr_n;
                                word_idx_d   = '0;
                                core_reset_d = 1'b1;
                            end
                        end
                        OP_RUN: begin
                            state_d   = S_RUN;
                            run_cnt_d = hdr_c;
                        end
                        OP_DUMP: begin
                            state_d    = S_SEL;
                            sel_d      = hdr_s;
                            dump_cnt_d = hdr_k;
                        end
                        OP_RST: begin
                            state_d      = S_RST1;
                            core_reset_d = 1'b1;
                            halt_d       = 1'b1;
                        end
                    endcase
                end
            end
            S_COLLECT: begin
                if (s_fire) begin
                    word_idx_d = word_idx_q + 2'd1;
                    unique case (word_idx_q)
                        2'd0: inst1_d = host.s_data;
                        2'd1: inst2_d = host.s_data;
                        2'd2: data1_d = host.s_data;
                        2'd3: begin
                            data2_d   = host.s_data;
                            wr_en_d   = 1'b1;
                            wr_addr_d = addr_q;
                            state_d   = S_WRITE;
                        end
                    endcase
                end
            end
            S_WRITE: begin
                addr_d  = addr_q + 1'b1;
                beats_d = beats_q - 9'd1;
                state_d = (beats_q == 9'd1) ? S_IDLE : S_COLLECT;
            end
            // The first RUN cycle releases the core; a zero count halts straight away.
            S_RUN: begin
                core_reset_d = 1'b0;
                if (run_cnt_q == '0) begin
                    halt_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    halt_d    = 1'b0;
                    run_cnt_d = run_cnt_q - 24'd1;
                end
            end
            // DebugSel has had one cycle to settle; capture the register value.
            S_SEL: begin
                m_data_d = DebugOutput;
                state_d  = S_SAMPLE;
            end
            S_SAMPLE: begin
                m_valid_d = 1'b1;
                m_last_d  = (dump_cnt_q == '0);
                state_d   = S_PUSH;
            end
            S_PUSH: begin
                if (m_fire) begin
                    m_valid_d = 1'b0;
                    m_last_d  = 1'b0;
                    if (dump_cnt_q == '0) begin
                        state_d = S_IDLE;
                    end else begin
                        dump_cnt_d = dump_cnt_q - 5'd1;
                        sel_d      = DebugSel + 5'd1;
                        state_d    = S_SEL;
                    end
                end
            end
            S_RST1: state_d = S_RST2;
            S_RST2: begin
                core_reset_d = 1'b0;
                halt_d       = 1'b1;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q            <= S_IDLE;
            word_idx_q         <= '0;
            addr_q             <= '0;
            beats_q            <= '0;
            run_cnt_q          <= '0;
            dump_cnt_q         <= '0;
            core_reset         <= 1'b1;
            enable_halt        <= 1'b0;
            enable_load_ex_mem <= 1'b0;
            InstExMemAddress   <= '0;
            DataExMemAddress   <= '0;
            InstExMemData1     <= '0;
            InstExMemData2     <= '0;
            DataExMemData1     <= '0;
            DataExMemData2     <= '0;
            DebugSel           <= '0;
            host.s_ready       <= 1'b0;
            host.m_valid       <= 1'b0;
            host.m_data        <= '0;
            host.m_last        <= 1'b0;
            busy               <= 1'b0;
        end else begin
            state_q            <= state_d;
            word_idx_q         <= word_idx_d;
            addr_q             <= addr_d;
            beats_q            <= beats_d;
            run_cnt_q          <= run_cnt_d;
            dump_cnt_q         <= dump_cnt_d;
            core_reset         <= core_reset_d;
            enable_halt        <= halt_d;
            enable_load_ex_mem <= wr_en_d;
            InstExMemAddress   <= wr_addr_d;
            DataExMemAddress   <= wr_addr_d;
            InstExMemData1     <= inst1_d;
            InstExMemData2     <= inst2_d;
            DataExMemData1     <= data1_d;
            DataExMemData2     <= data2_d;
            DebugSel           <= sel_d;
            host.s_ready       <= (state_d == S_IDLE) || (state_d == S_COLLECT);
            host.m_valid       <= m_valid_d;
            host.m_data        <= m_data_d;
            host.m_last        <= m_last_d;
            busy               <= (state_d != S_IDLE);
        end
    end

endmodule

// File: tb/tb_ex_mem_loader.sv
// Scoreboard bench for ex_mem_loader: expected ex-mem writes and dump words are
// queued as commands are issued and compared by an independent monitor.
module tb_ex_mem_loader;
    import ex_loader_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        busy, core_reset, enable_load_ex_mem, enable_halt;
    logic [8:0]  InstExMemAddress, DataExMemAddress;
    logic [31:0] InstExMemData1, InstExMemData2, DataExMemData1, DataExMemData2;
    logic [4:0]  DebugSel;
    logic [31:0] DebugOutput;

    ex_mem_loader_if #(.DATA_W(32)) bus ();

    ex_mem_loader #(.ADDR_W(9), .DATA_W(32)) dut (
        .clk                (clk),
        .reset              (reset),
        .host               (bus),
        .busy               (busy),
        .core_reset         (core_reset),
        .enable_load_ex_mem (enable_load_ex_mem),
        .enable_halt        (enable_halt),
        .InstExMemAddress   (InstExMemAddress),
        .InstExMemData1     (InstExMemData1),
        .InstExMemData2     (InstExMemData2),
        .DataExMemAddress   (DataExMemAddress),
        .DataExMemData1     (DataExMemData1),
        .DataExMemData2     (DataExMemData2),
        .DebugSel           (DebugSel),
        .DebugOutput        (DebugOutput)
    );

    always #5 clk = ~clk;

    // Stand-in for the core's register file: a fixed, distinct value per select.
    function automatic logic [31:0] dbg_model(input logic [4:0] s);
        return 32'hC0DE_0011 + 32'(s) * 32'h0000_0401;
    endfunction

    assign DebugOutput = dbg_model(DebugSel);

    typedef struct packed {
        logic [8:0]  addr;
        logic [31:0] i1, i2, d1, d2;
    } wr_t;

    typedef struct packed {
        logic [4:0]  sel;
        logic [31:0] data;
        logic        last;
    } dm_t;

    wr_t wr_q[$];
    dm_t dm_q[$];
    wr_t mon_wr;
    dm_t mon_dm;
    int  n_checks = 0;
    int  n_pass   = 0;
    bit  rand_ready = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    endtask

    task automatic fail(input string name, input string msg);
        n_checks++;
        $display("FAIL %s: %s", name, msg);
    endtask

    // Monitor: every strobe cycle and every accepted dump word pops one expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (enable_load_ex_mem) begin
                    if (wr_q.size() == 0) begin
                        fail("unexpected_strobe", $sformatf("strobe at addr %0d, none required", InstExMemAddress));
                    end else begin
                        mon_wr = wr_q.pop_front();
                        check("wr_inst_addr", 32'(InstExMemAddress), 32'(mon_wr.addr));
                        check("wr_data_addr", 32'(DataExMemAddress), 32'(mon_wr.addr));
                        check("wr_inst1", InstExMemData1, mon_wr.i1);
                        check("wr_inst2", InstExMemData2, mon_wr.i2);
                        check("wr_data1", DataExMemData1, mon_wr.d1);
                        check("wr_data2", DataExMemData2, mon_wr.d2);
                        check("wr_core_reset_held", 32'(core_reset), 32'd1);
                    end
                end
                if (bus.m_valid && bus.m_ready) begin
                    if (dm_q.size() == 0) begin
                        fail("unexpected_dump_word", $sformatf("word 0x%08h, none required", bus.m_data));
                    end else begin
                        mon_dm = dm_q.pop_front();
                        check("dump_sel", 32'(DebugSel), 32'(mon_dm.sel));
                        check("dump_data", bus.m_data, mon_dm.data);
                        check("dump_last", 32'(bus.m_last), 32'(mon_dm.last));
                    end
                end
            end
        end
    end

    initial begin
        bus.m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.m_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Entered and left just after a rising edge; returns right after the accepting edge.
    task automatic send(input logic [31:0] w, input int gap);
        bit acc = 1'b0;
        int budget = 200;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        bus.s_valid = 1'b1;
        bus.s_data  = w;
        while (!acc && budget > 0) begin
            @(negedge clk);
            acc = bus.s_ready;
            @(posedge clk);
            #1;
            budget--;
        end
        bus.s_valid = 1'b0;
        if (!acc) fail("send_timeout", $sformatf("word 0x%08h never accepted", w));
    endtask

    task automatic wait_idle(input string name);
        bit idle = 1'b0;
        int budget = 2000;
        while (!idle && budget > 0) begin
            @(negedge clk);
            idle = !busy;
            budget--;
        end
        if (!idle) fail({name, "_idle_timeout"}, "busy never fell");
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_core_reset"}, 32'(core_reset), 32'd1);
        check({tag, "_halt"}, 32'(enable_halt), 32'd0);
        check({tag, "_strobe"}, 32'(enable_load_ex_mem), 32'd0);
        check({tag, "_s_ready"}, 32'(bus.s_ready), 32'd0);
        check({tag, "_m_valid_last"}, 32'({bus.m_valid, bus.m_last}), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_addr_sel"}, 32'({InstExMemAddress, DataExMemAddress, DebugSel}), 32'd0);
        check({tag, "_data"}, InstExMemData1 | InstExMemData2 | DataExMemData1 | DataExMemData2 | bus.m_data, 32'd0);
    endtask

    task automatic do_load(input int n, input int a, input int gap, input bit rnd_gap);
        logic [31:0] w[4];
        wr_t e;
        send(32'((n << 9) | a), 0);
        for (int b = 0; b < n; b++) begin
            for (int j = 0; j < 4; j++) w[j] = $urandom;
            e.addr = 9'((a + b) % 512);
            e.i1 = w[0];
            e.i2 = w[1];
            e.d1 = w[2];
            e.d2 = w[3];
            wr_q.push_back(e);
            for (int j = 0; j < 4; j++) send(w[j], rnd_gap ? int'($urandom_range(0, gap)) : gap);
        end
        wait_idle("load");
        check("load_queue_drained", 32'(wr_q.size()), 32'd0);
    endtask

    task automatic do_run(input int c, input logic prev_core_reset);
        int   run_cycles = 0;
        logic halt_k1 = 1'b0;
        send(32'h4000_0000 | 32'(c), 0);
        check("run_core_reset_hdr_edge", 32'(core_reset), 32'(prev_core_reset));
        for (int k = 1; k <= c + 4; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) halt_k1 = enable_halt;
            if (!core_reset && !enable_halt) run_cycles++;
        end
        check("run_cycles", 32'(run_cycles), 32'(c));
        check("run_halt_first_cycle", 32'(halt_k1), 32'(c == 0));
        check("run_end_state", 32'({core_reset, enable_halt, busy}), 32'b010);
    endtask

    task automatic do_dump(input int s, input int k);
        dm_t e;
        for (int i = 0; i < k; i++) begin
            e.sel  = 5'((s + i) % 32);
            e.data = dbg_model(e.sel);
            e.last = (i == k - 1);
            dm_q.push_back(e);
        end
        rand_ready = 1'b1;
        send(32'h8000_0000 | 32'(((k - 1) << 5) | s), 0);
        wait_idle("dump");
        rand_ready = 1'b0;
        check("dump_queue_drained", 32'(dm_q.size()), 32'd0);
        check("dump_levels_kept", 32'({core_reset, enable_halt}), 32'b01);
    endtask

    initial begin
        wr_t e;
        int  cnt;
        reset       = 1'b1;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;

        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("por");
        reset = 1'b0;
        check("s_ready_before_edge", 32'(bus.s_ready), 32'd0);
        @(posedge clk);
        #1;
        check("s_ready_first_edge", 32'(bus.s_ready), 32'd1);

        // One beat with the reference program words, timed around the write cycle.
        e = '{addr: 9'd0, i1: 32'h0010_0393, i2: 32'h0003_8303, d1: 32'h0000_8F00, d2: 32'h0000_00FF};
        wr_q.push_back(e);
        send(32'h0000_0200, 0);
        send(e.i1, 0);
        send(e.i2, 0);
        send(e.d1, 0);
        send(e.d2, 0);
        check("beat_strobe_at_t", 32'({enable_load_ex_mem, bus.s_ready}), 32'b10);
        @(posedge clk);
        #1;
        check("beat_after_write", 32'({enable_load_ex_mem, bus.s_ready, busy}), 32'b010);
        check("beat_queue_drained", 32'(wr_q.size()), 32'd0);

        do_load(2, 511, 1, 1'b0);
        do_load(int'($urandom_range(1, 3)), int'($urandom_range(0, 511)), 2, 1'b1);
        check("core_reset_after_loads", 32'(core_reset), 32'd1);

        do_run(10, 1'b1);
        do_run(int'($urandom_range(1, 15)), 1'b0);

        do_dump(26, 8);
        do_dump(int'($urandom_range(0, 31)), int'($urandom_range(1, 32)));

        send(32'hC000_0000, 0);
        cnt = core_reset ? 1 : 0;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            #1;
            if (core_reset) cnt++;
        end
        check("rst_op_pulse_cycles", 32'(cnt), 32'(RST_PULSE_CYCLES));
        check("rst_op_end_state", 32'({core_reset, enable_halt, busy}), 32'b010);

        // Asynchronous reset with a partial beat in flight: nothing may be written.
        send(32'((1 << 9) | 5), 0);
        for (int j = 0; j < 3; j++) send($urandom, 0);
        reset = 1'b1;
        #2;
        check_reset_vals("async");
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("async_s_ready_back", 32'(bus.s_ready), 32'd1);

        do_run(0, 1'b1);

        send(32'h0000_0007, 0);
        check("empty_load_ready", 32'({bus.s_ready, busy}), 32'b10);
        repeat (4) @(posedge clk);
        #1;
        check("empty_load_no_write", 32'(wr_q.size()), 32'd0);

        do_load(1, int'($urandom_range(0, 511)), 2, 1'b1);

        repeat (4) @(posedge clk);
        #1;
        check("final_queues_empty", 32'(wr_q.size() + dm_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
